// File: rtl/connect4_board_ctrl.sv
// Connect-4 game-state owner: column drops, gravity, win/draw detection, turn order.
// Define CONNECT4_FALL_ANIM_EN to add the falling-token animation (FALL state + tick counter).
module connect4_board_ctrl #(
  parameter int FALL_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_game,
  input  logic                 drop_valid,
  output logic                 drop_ready,
  input  logic [6:0]           col_sel,
  output logic                 illegal,
  output logic [5:0][6:0][1:0] panel,
  output logic [6:0]           play,
  output logic                 player,
  output logic [1:0]           winner
);

  typedef enum logic [1:0] {IDLE, FALL, CHECK, OVER} state_e;
  typedef logic [5:0][6:0][1:0] board_t;

  state_e      state_q, state_d;
  board_t      panel_q, panel_d;
  logic [6:0]  play_q, play_d;
  logic        player_q, player_d;
  logic [1:0]  winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic        ready_q, ready_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;

`ifdef CONNECT4_FALL_ANIM_EN
  localparam int TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    cur_q, cur_d;
  logic [2:0]    cur_nxt;
  assign cur_nxt = cur_q - 3'd1;
`endif

  logic [2:0] sel_idx;
  logic [2:0] tgt_row;
  logic       legal;
  logic       board_full;
  logic       win;
  logic [1:0] mover;

  // True when the run through (r0,c0) along any of the four directions reaches 4.
  function automatic logic line_win(input board_t p, input logic [2:0] r0,
                                    input logic [2:0] c0, input logic [1:0] who);
    logic hit;
    logic alive;
    int   run, r, c, dr, dc;
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dr  = (d == 0) ? 0 : 1;
      dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      run = 1;
      for (int sgn = -1; sgn <= 1; sgn += 2) begin
        alive = 1'b1;
        for (int s = 1; s < 4; s++) begin
          r = int'(r0) + sgn * s * dr;
          c = int'(c0) + sgn * s * dc;
          if (alive && r >= 0 && r < 6 && c >= 0 && c < 7) begin
            if (p[r[2:0]][c[2:0]] == who) run++;
            else alive = 1'b0;
          end else begin
            alive = 1'b0;
          end
        end
      end
      if (run >= 4) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    sel_idx    = 3'd0;
    tgt_row    = 3'd0;
    board_full = 1'b1;
    for (int j = 0; j < 7; j++) if (col_sel[j]) sel_idx = 3'(j);
    // Scan top-down so the last hit is the lowest empty row.
    for (int r = 5; r >= 0; r--) if (panel_q[r][sel_idx] == 2'b00) tgt_row = 3'(r);
    for (int j = 0; j < 7; j++) if (panel_q[5][j] == 2'b00) board_full = 1'b0;
    legal = $onehot(col_sel) && (panel_q[5][sel_idx] == 2'b00);
    mover = player_q ? 2'b10 : 2'b01;
    win   = line_win(panel_q, row_q, col_q, mover);
  end

  always_comb begin
    state_d   = state_q;
    panel_d   = panel_q;
    play_d    = play_q;
    player_d  = player_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
    col_d     = col_q;
    row_d     = row_q;
`ifdef CONNECT4_FALL_ANIM_EN
    tick_d    = tick_q;
    cur_d     = cur_q;
`endif
    if (new_game) begin
      state_d  = IDLE;
      panel_d  = '0;
      play_d   = '0;
      player_d = 1'b0;
      winner_d = 2'b00;
`ifdef CONNECT4_FALL_ANIM_EN
      tick_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (drop_valid) begin
            if (!legal) begin
              illegal_d = 1'b1;
            end else begin
              col_d  = sel_idx;
              row_d  = tgt_row;
              play_d = col_sel;
`ifdef CONNECT4_FALL_ANIM_EN
              panel_d[5][sel_idx] = mover;
              cur_d   = 3'd5;
              tick_d  = '0;
              state_d = (tgt_row == 3'd5) ? CHECK : FALL;
`else
              panel_d[tgt_row][sel_idx] = mover;
              state_d = CHECK;
`endif
            end
          end
        end
        FALL: begin
`ifdef CONNECT4_FALL_ANIM_EN
          if (tick_q == TW'(FALL_TICKS - 1)) begin
            panel_d[cur_q][col_q]   = 2'b00;
            panel_d[cur_nxt][col_q] = mover;
            cur_d  = cur_nxt;
            tick_d = '0;
            if (cur_nxt == row_q) state_d = CHECK;
          end else begin
            tick_d = tick_q + TW'(1);
          end
`else
          state_d = IDLE;
`endif
        end
        CHECK: begin
          if (win) begin
            winner_d = mover;
            state_d  = OVER;
          end else if (board_full) begin
            winner_d = 2'b11;
            state_d  = OVER;
          end else begin
            player_d = ~player_q;
            state_d  = IDLE;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      panel_q   <= '0;
      play_q    <= '0;
      player_q  <= 1'b0;
      winner_q  <= 2'b00;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      col_q     <= '0;
      row_q     <= '0;
`ifdef CONNECT4_FALL_ANIM_EN
      tick_q    <= '0;
      cur_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      panel_q   <= panel_d;
      play_q    <= play_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      col_q     <= col_d;
      row_q     <= row_d;
`ifdef CONNECT4_FALL_ANIM_EN
      tick_q    <= tick_d;
      cur_q     <= cur_d;
`endif
    end
  end

  assign panel      = panel_q;
  assign play       = play_q;
  assign player     = player_q;
  assign winner     = winner_q;
  assign illegal    = illegal_q;
  assign drop_ready = ready_q;

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Bench for connect4_board_ctrl: directed game scenarios plus random games vs a board model.
module tb_connect4_board_ctrl;
  localparam int FT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 new_game = 1'b0;
  logic                 drop_valid = 1'b0;
  logic [6:0]           col_sel = '0;
  logic                 drop_ready, illegal, player;
  logic [5:0][6:0][1:0] panel;
  logic [6:0]           play;
  logic [1:0]           winner;

  int total = 0;
  int bad   = 0;
  int brd[6][7];
  int mplayer, mwinner;

  connect4_board_ctrl #(.FALL_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .drop_valid(drop_valid),
    .drop_ready(drop_ready), .col_sel(col_sel), .illegal(illegal), .panel(panel),
    .play(play), .player(player), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0][6:0][1:0] pack();
    logic [5:0][6:0][1:0] p;
    p = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) p[r][c] = 2'(brd[r][c]);
    return p;
  endfunction

  function automatic bit has_four();
    int dr, dc, rr, cc, v;
    bit ok;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          v  = brd[r][c];
          ok = (v != 0);
          for (int k = 1; k < 4; k++) begin
            rr = r + k * dr;
            cc = c + k * dc;
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 0;
            else if (brd[rr][cc] != v) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction

  function automatic bit top_full();
    for (int c = 0; c < 7; c++) if (brd[5][c] == 0) return 0;
    return 1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) brd[r][c] = 0;
    mplayer = 0;
    mwinner = 0;
  endtask

  task automatic check_clear(input string tag);
    chk({tag, "_panel"},  panel, '0);
    chk({tag, "_play"},   play, '0);
    chk({tag, "_player"}, player, '0);
    chk({tag, "_winner"}, winner, '0);
    chk({tag, "_illegal"}, illegal, '0);
    chk({tag, "_ready"},  drop_ready, 1);
  endtask

  task automatic ng();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_clear();
    check_clear("new_game");
  endtask

  // One request through the DUT, judged against the model.
  task automatic do_drop(input logic [6:0] sel);
    logic [5:0][6:0][1:0] pre, ep;
    int col, t;
    pre = pack();
    drop_valid = 1'b1;
    col_sel    = sel;
    step();
    drop_valid = 1'b0;
    col_sel    = '0;
    if (mwinner != 0) begin
      chk("over_illegal", illegal, 0);
      chk("over_panel", panel, pre);
      chk("over_ready", drop_ready, 0);
      return;
    end
    col = -1;
    if ($countones(sel) == 1)
      for (int j = 0; j < 7; j++) if (sel[j]) col = j;
    if (col < 0 || brd[5][col] != 0) begin
      chk("illegal_pulse", illegal, 1);
      chk("illegal_panel", panel, pre);
      chk("illegal_player", player, mplayer);
      step();
      chk("illegal_drop", illegal, 0);
      chk("illegal_ready", drop_ready, 1);
      return;
    end
    t = 0;
    while (brd[t][col] != 0) t++;
`ifdef CONNECT4_FALL_ANIM_EN
    ep = pre;
    ep[5][col] = 2'(mplayer + 1);
    chk("fall_top", panel, ep);
    repeat ((5 - t) * FT) step();
`endif
    brd[t][col] = mplayer + 1;
    chk("landed_panel", panel, pack());
    chk("landed_play", play, sel);
    chk("landed_ready", drop_ready, 0);
    chk("landed_illegal", illegal, 0);
    step();
    if (has_four()) mwinner = mplayer + 1;
    else if (top_full()) mwinner = 3;
    else mplayer ^= 1;
    chk("result_winner", winner, mwinner);
    chk("result_player", player, mplayer);
    chk("result_ready", drop_ready, (mwinner == 0));
  endtask

  initial begin
    int seq[7];
    int pa[3], pb[3];
    logic [6:0] rs;
    model_clear();
    #12;
    check_clear("reset");
    @(negedge clk) rst = 1'b1;

    // First drop, then a vertical win for player 0 in column 0.
    do_drop(7'b0000001);
    chk("first_cell", panel[0][0], 2'b01);
    seq = '{1, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) do_drop(7'(1 << seq[i]));
    chk("vertical_win", winner, 2'b01);
    do_drop(7'b0000100);
    do_drop(7'b0000001);

    // Full column and non-one-hot rejects.
    ng();
    for (int i = 0; i < 6; i++) do_drop(7'b0001000);
    do_drop(7'b0001000);
    do_drop(7'b0000011);
    do_drop(7'b0000000);

    // 42-move draw: paired columns a,b,b,a then column 5 alone.
    ng();
    pa = '{0, 1, 4};
    pb = '{2, 3, 6};
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 3; k++) begin
        do_drop(7'(1 << pa[p]));
        do_drop(7'(1 << pb[p]));
        do_drop(7'(1 << pb[p]));
        do_drop(7'(1 << pa[p]));
      end
    for (int k = 0; k < 6; k++) do_drop(7'b0100000);
    chk("draw", winner, 2'b11);

    // new_game mid-move, and new_game beating a simultaneous accept.
    ng();
    drop_valid = 1'b1;
    col_sel    = 7'b1000000;
    step();
    drop_valid = 1'b0;
    col_sel    = '0;
`ifdef CONNECT4_FALL_ANIM_EN
    repeat (5) step();
`endif
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_clear();
    check_clear("ng_mid_move");
    drop_valid = 1'b1;
    col_sel    = 7'b0000001;
    new_game   = 1'b1;
    step();
    drop_valid = 1'b0;
    col_sel    = '0;
    new_game   = 1'b0;
    check_clear("ng_over_accept");

    // Asynchronous reset in the middle of a move.
    do_drop(7'b0010000);
    do_drop(7'b0010000);
    drop_valid = 1'b1;
    col_sel    = 7'b0000010;
    step();
    drop_valid = 1'b0;
    col_sel    = '0;
`ifdef CONNECT4_FALL_ANIM_EN
    repeat (3) step();
`endif
    #2 rst = 1'b0;
    #1 check_clear("async_reset");
    @(negedge clk) rst = 1'b1;
    model_clear();

    // Random games.
    for (int g = 0; g < 6; g++) begin
      ng();
      for (int m = 0; m < 48; m++) begin
        if ($urandom_range(0, 9) == 0) rs = 7'($urandom_range(0, 127));
        else rs = 7'(1 << $urandom_range(0, 6));
        do_drop(rs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
